// File: rtl/source_scheduler_pkg.sv
// source_scheduler shared types: mode codes, FSM states, words per group.
// Optional: SOURCE_SCHEDULER_TEST_PATTERN_EN makes mode 3 a supported mode.
package source_scheduler_pkg;

  localparam logic [7:0] MODE_QUANT3 = 8'd0;
  localparam logic [7:0] MODE_RAW_I  = 8'd1;
  localparam logic [7:0] MODE_RAW_Q  = 8'd2;
  localparam logic [7:0] MODE_TEST   = 8'd3;

  localparam int WPG_QUANT = 3;
  localparam int WPG_RAW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } state_t;

  function automatic logic mode_ok(input logic [7:0] m);
`ifdef SOURCE_SCHEDULER_TEST_PATTERN_EN
    return (m <= MODE_TEST);
`else
    return (m <= MODE_RAW_Q);
`endif
  endfunction

endpackage

// File: rtl/source_group_packer.sv
// Capture shift register, tagged output group register, phase word select.
// In: samples, capture/load/emit strobes, phase, mode. Out: word, en, last, test.
module source_group_packer
  import source_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture,
  input  logic        load,
  input  logic        last_in,
  input  logic        emit,
  input  logic [1:0]  phase,
  input  logic [1:0]  mode_cap,
  input  logic [15:0] pattern,
  input  logic [1:0]  ch1_si,
  input  logic [1:0]  ch1_sq,
  input  logic [1:0]  ch2_si,
  input  logic [1:0]  ch2_sq,
  input  logic [1:0]  ch3_si,
  input  logic [1:0]  ch3_sq,
  input  logic [7:0]  ch1_i,
  input  logic [7:0]  ch1_q,
  output logic [15:0] word,
  output logic        word_en,
  output logic        word_last,
  output logic        word_test
);

  logic [11:0] set_q;
  logic [47:0] sh;
  logic [47:0] sh_nxt;
  logic [47:0] grp_q;
  logic [1:0]  tag;
  logic        last_q;
  logic        is_quant;
  logic        is_test;

  assign set_q = {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq};

  always_comb begin
    sh_nxt = sh;
    unique case ({6'd0, mode_cap})
      MODE_QUANT3: sh_nxt = {sh[35:0], set_q};
      MODE_RAW_I:  sh_nxt = {sh[39:0], ch1_i};
      MODE_RAW_Q:  sh_nxt = {sh[39:0], ch1_q};
      default:     sh_nxt = sh;
    endcase
  end

  // The output group keeps its own mode tag so a mode change at a
  // packet boundary never reformats words still being emitted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh     <= '0;
      grp_q  <= '0;
      tag    <= '0;
      last_q <= 1'b0;
    end else begin
      if (capture) sh <= sh_nxt;
      if (load) begin
        grp_q  <= sh_nxt;
        tag    <= mode_cap;
        last_q <= last_in;
      end
    end
  end

  assign is_quant = ({6'd0, tag} == MODE_QUANT3);
  assign is_test  = ({6'd0, tag} == MODE_TEST);

  always_comb begin
    word    = '0;
    word_en = 1'b0;
    if (emit) begin
      unique case (1'b1)
        is_quant: begin
          word_en = (phase != 2'd3);
          word    = (phase == 2'd0) ? grp_q[47:32] :
                    (phase == 2'd1) ? grp_q[31:16] : grp_q[15:0];
        end
        is_test: begin
          word_en = (phase != 2'd3);
          word    = pattern;
        end
        default: begin
          word_en = (phase == 2'd0) || (phase == 2'd2);
          word    = (phase == 2'd0) ? grp_q[31:16] : grp_q[15:0];
        end
      endcase
      if (!word_en) word = '0;
    end
  end

  assign word_last = word_en && (phase == 2'd2) && last_q;
  assign word_test = word_en && is_test;

endmodule

// File: rtl/source_scheduler.sv
// Sample-source FSM: packetised capture of ADC groups for packet_streamer.
// Optional macro SOURCE_SCHEDULER_TEST_PATTERN_EN adds mode 3 counter words.
module source_scheduler
  import source_scheduler_pkg::*;
#(
  parameter int GROUPS_PER_PACKET = 240,
  parameter int PKT_CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [7:0]           mode,
  input  logic [1:0]           ch1_si,
  input  logic [1:0]           ch1_sq,
  input  logic [1:0]           ch2_si,
  input  logic [1:0]           ch2_sq,
  input  logic [1:0]           ch3_si,
  input  logic [1:0]           ch3_sq,
  input  logic [7:0]           ch1_i,
  input  logic [7:0]           ch1_q,
  output logic [15:0]          source_data,
  output logic                 source_en,
  output logic                 source_packet_end,
  output logic [7:0]           mode_active,
  output logic                 busy,
  output logic                 mode_err,
  output logic [PKT_CNT_W-1:0] packet_count
);

  localparam int GW = $clog2(GROUPS_PER_PACKET) + 1;
  localparam logic [GW-1:0] G_LAST = GW'(GROUPS_PER_PACKET - 1);

  state_t        state;
  logic [1:0]    phase;
  logic [GW-1:0] grp;
  logic [15:0]   pattern;
  logic          capture;
  logic          load;
  logic          emit;
  logic          req_ok;
  logic [15:0]   word;
  logic          word_en;
  logic          word_last;
  logic          word_test;

  assign capture = (state == ST_FILL) || (state == ST_RUN);
  assign load    = capture && (phase == 2'd3);
  assign emit    = (state == ST_RUN) || (state == ST_DRAIN);
  assign req_ok  = mode_ok(mode);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      phase       <= '0;
      grp         <= '0;
      mode_active <= '0;
      mode_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      phase <= (state == ST_IDLE) ? 2'd0 : phase + 2'd1;
      unique case (state)
        ST_IDLE: begin
          if (enable && req_ok) begin
            state       <= ST_FILL;
            mode_active <= mode;
            mode_err    <= 1'b0;
            busy        <= 1'b1;
            grp         <= '0;
          end else if (enable) begin
            mode_err <= 1'b1;
          end
        end
        ST_FILL, ST_RUN: begin
          if (phase == 2'd3) begin
            if (grp != G_LAST) begin
              grp   <= grp + GW'(1);
              state <= ST_RUN;
            end else if (enable && req_ok) begin
              mode_active <= mode;
              grp         <= '0;
              state       <= ST_RUN;
            end else begin
              state <= ST_DRAIN;
              if (!req_ok) mode_err <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (phase == 2'd3) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  source_group_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture),
    .load      (load),
    .last_in   (grp == G_LAST),
    .emit      (emit),
    .phase     (phase),
    .mode_cap  (mode_active[1:0]),
    .pattern   (pattern),
    .ch1_si    (ch1_si),
    .ch1_sq    (ch1_sq),
    .ch2_si    (ch2_si),
    .ch2_sq    (ch2_sq),
    .ch3_si    (ch3_si),
    .ch3_sq    (ch3_sq),
    .ch1_i     (ch1_i),
    .ch1_q     (ch1_q),
    .word      (word),
    .word_en   (word_en),
    .word_last (word_last),
    .word_test (word_test)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      source_data       <= '0;
      source_en         <= 1'b0;
      source_packet_end <= 1'b0;
      packet_count      <= '0;
    end else begin
      source_data       <= word;
      source_en         <= word_en;
      source_packet_end <= word_last;
      if (word_last) packet_count <= packet_count + 1'b1;
    end
  end

`ifdef SOURCE_SCHEDULER_TEST_PATTERN_EN
  // Wraps on the packet's last word so every test packet starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern <= '0;
    end else if (state == ST_IDLE) begin
      pattern <= '0;
    end else if (word_test) begin
      pattern <= word_last ? 16'd0 : pattern + 16'd1;
    end
  end
`else
  logic unused_test;
  assign pattern     = '0;
  assign unused_test = word_test;
`endif

endmodule

// File: tb/tb_source_scheduler.sv
// Randomized bench for source_scheduler against a group-level reference model.
// Model schedules each completed group's words by absolute clock edge.
module tb_source_scheduler;

  localparam int G = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  mode = '0;
  logic [1:0]  ch1_si = '0, ch1_sq = '0, ch2_si = '0;
  logic [1:0]  ch2_sq = '0, ch3_si = '0, ch3_sq = '0;
  logic [7:0]  ch1_i = '0, ch1_q = '0;
  logic [15:0] source_data;
  logic        source_en;
  logic        source_packet_end;
  logic [7:0]  mode_active;
  logic        busy;
  logic        mode_err;
  logic [15:0] packet_count;

  source_scheduler #(
    .GROUPS_PER_PACKET (G),
    .PKT_CNT_W         (16)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .mode              (mode),
    .ch1_si            (ch1_si),
    .ch1_sq            (ch1_sq),
    .ch2_si            (ch2_si),
    .ch2_sq            (ch2_sq),
    .ch3_si            (ch3_si),
    .ch3_sq            (ch3_sq),
    .ch1_i             (ch1_i),
    .ch1_q             (ch1_q),
    .source_data       (source_data),
    .source_en         (source_en),
    .source_packet_end (source_packet_end),
    .mode_active       (mode_active),
    .busy              (busy),
    .mode_err          (mode_err),
    .packet_count      (packet_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct {
    int          e;
    logic [15:0] d;
    bit          last;
  } word_t;

  word_t       wq[$];
  int          edge_n = 0;
  bit          m_busy, m_drain, m_err;
  int          m_dcnt, m_cyc, m_grp;
  logic [7:0]  m_mode;
  logic [15:0] m_pcount;
  logic [11:0] q[4];
  logic [7:0]  r[4];

  function automatic bit supp(input logic [7:0] m);
`ifdef SOURCE_SCHEDULER_TEST_PATTERN_EN
    return m <= 8'd3;
`else
    return m <= 8'd2;
`endif
  endfunction

  task automatic model_reset();
    wq.delete();
    m_busy = 0; m_drain = 0; m_err = 0;
    m_dcnt = 0; m_cyc = 0; m_grp = 0;
    m_mode = '0; m_pcount = '0;
  endtask

  task automatic push(input int k, input logic [15:0] d);
    word_t w;
    w.e = edge_n + 1 + k;
    w.d = d;
    w.last = (k == 2) && (m_grp == G - 1);
    wq.push_back(w);
  endtask

  task automatic group_done();
    logic [47:0] w48;
    w48 = {q[0], q[1], q[2], q[3]};
    case (m_mode)
      8'd0: begin
        push(0, w48[47:32]); push(1, w48[31:16]); push(2, w48[15:0]);
      end
      8'd1, 8'd2: begin
        push(0, {r[0], r[1]}); push(2, {r[2], r[3]});
      end
      default: begin
        for (int k = 0; k < 3; k++) push(k, 16'(m_grp * 3 + k));
      end
    endcase
    if (m_grp != G - 1) begin
      m_grp++;
    end else if (enable && supp(mode)) begin
      m_mode = mode;
      m_grp = 0;
    end else begin
      m_drain = 1;
      m_dcnt = 0;
      if (!supp(mode)) m_err = 1;
    end
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (enable && supp(mode)) begin
        m_busy = 1; m_mode = mode; m_err = 0;
        m_cyc = 0; m_grp = 0; m_drain = 0;
      end else if (enable) begin
        m_err = 1;
      end
    end else if (m_drain) begin
      m_dcnt++;
      if (m_dcnt == 4) begin
        m_busy = 0;
        m_drain = 0;
      end
    end else begin
      q[m_cyc] = {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq};
      r[m_cyc] = (m_mode == 8'd2) ? ch1_q : ch1_i;
      if (m_cyc == 3) group_done();
      m_cyc = (m_cyc + 1) % 4;
    end
  endtask

  task automatic step();
    logic [15:0] ed;
    bit          een, elast;
    @(posedge clk);
    #1;
    edge_n++;
    if (!reset_n) model_reset();
    else model_edge();
    ed = '0; een = 0; elast = 0;
    if (wq.size() > 0 && wq[0].e == edge_n) begin
      ed = wq[0].d; een = 1; elast = wq[0].last;
      void'(wq.pop_front());
      if (elast) m_pcount++;
    end
    chk("source_en", source_en, een);
    chk("source_data", source_data, ed);
    chk("packet_end", source_packet_end, elast);
    chk("packet_count", packet_count, m_pcount);
    chk("busy", busy, m_busy);
    chk("mode_active", mode_active, m_mode);
    chk("mode_err", mode_err, m_err);
    @(negedge clk);
    {ch1_si, ch1_sq, ch2_si, ch2_sq, ch3_si, ch3_sq} = 12'($urandom);
    ch1_i = 8'($urandom);
    ch1_q = 8'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle();
    int budget;
    budget = 200;
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) chk("idle_timeout", busy, 1'b0);
    run(2);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_en", source_en, 1'b0);
    chk("rst_data", source_data, 16'd0);
    chk("rst_pend", source_packet_end, 1'b0);
    chk("rst_count", packet_count, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mode", mode_active, 8'd0);
    chk("rst_err", mode_err, 1'b0);
    model_reset();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    run(3);
    reset_n = 1'b1;
    run(2);

    mode = 8'd0; enable = 1'b1;
    run(22);
    mode = 8'd2;
    run(40);
    enable = 1'b0;
    wait_idle();

    mode = 8'd1; enable = 1'b1;
    run(40);
    enable = 1'b0;
    wait_idle();

    mode = 8'd5; enable = 1'b1;
    run(8);
    mode = 8'd0;
    run(30);
    pulse_reset();
    mode = 8'd3; enable = 1'b1;
    run(40);
    enable = 1'b0;
    wait_idle();

    for (int s = 0; s < 60; s++) begin
      enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: mode = 8'd0;
        1: mode = 8'd1;
        2: mode = 8'd2;
        3: mode = 8'd3;
        4: mode = 8'd5;
        default: mode = 8'h83;
      endcase
      run($urandom_range(5, 60));
      if ($urandom_range(0, 14) == 0) pulse_reset();
    end
    enable = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
